// File: rtl/pc_seq_pkg.sv
// Shared types and constants for the program-counter sequencer.
// Holds the FSM state enum and the priority encoding of the next-PC select.
package pc_seq_pkg;

  typedef enum logic [1:0] {
    S_BOOT,
    S_RUN,
    S_HALT
  } state_e;

  typedef enum logic [2:0] {
    SEL_HOLD,
    SEL_BOOT,
    SEL_SEQ,
    SEL_TARGET,
    SEL_TRAP
  } pc_sel_e;

  localparam logic [31:0] ILEN           = 32'd4;
  localparam logic [3:0]  CAUSE_MISALIGN = 4'd0;

  // In RUN: halt and stall both hold, then any redirect beats the sequential step.
  function automatic pc_sel_e next_pc_sel(input state_e state,
                                          input logic   halt_req,
                                          input logic   stall,
                                          input logic   resume,
                                          input logic   redirect,
                                          input logic   trap_hit);
    pc_sel_e sel;
    sel = SEL_HOLD;
    case (state)
      S_BOOT: sel = SEL_BOOT;
      S_HALT: sel = resume ? SEL_SEQ : SEL_HOLD;
      default: begin
        if (halt_req || stall) sel = SEL_HOLD;
        else if (redirect)     sel = trap_hit ? SEL_TRAP : SEL_TARGET;
        else                   sel = SEL_SEQ;
      end
    endcase
    return sel;
  endfunction

endpackage

// File: rtl/pc_seq_target_sel.sv
// Redirect mux for the PC sequencer: jump beats branch, jump bit0 cleared,
// and a misaligned flag when the chosen target has bit1 set.
module pc_seq_target_sel
  import pc_seq_pkg::*;
(
  input  logic        jmp_valid,
  input  logic [31:0] jmp_target,
  input  logic        br_taken,
  input  logic [31:0] br_target,
  output logic [31:0] target,
  output logic        redirect,
  output logic        misaligned
);

  logic unused_jmp_bit0;

  assign unused_jmp_bit0 = jmp_target[0];

  assign target     = jmp_valid ? {jmp_target[31:1], 1'b0} : br_target;
  assign redirect   = jmp_valid | br_taken;
  assign misaligned = redirect & target[1];

endmodule

// File: rtl/pc_sequencer.sv
// Program counter sequencer: boot entry, sequential/branch/jump/stall/halt, instret.
// Optional misaligned-target trap enabled by macro PC_SEQ_MISALIGN_TRAP_EN.
module pc_sequencer
  import pc_seq_pkg::*;
#(
  parameter logic [31:0] RESET_VECTOR   = 32'h0000_0000,
  parameter logic [31:0] TRAP_VECTOR    = 32'h0000_0100,
  parameter int          BOOT_FROM_PORT = 1,
  parameter int          CNT_W          = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [31:0]      boot_addr,
  input  logic             stall,
  input  logic             br_taken,
  input  logic [31:0]      br_target,
  input  logic             jmp_valid,
  input  logic [31:0]      jmp_target,
  input  logic             halt_req,
  input  logic             resume,
  output logic [31:0]      pc_addr,
  output logic [31:0]      pc_plus4,
  output logic             pc_valid,
  output logic [CNT_W-1:0] instret,
  output logic             trap_valid,
  output logic [31:0]      epc
);

  state_e           state, next_state;
  pc_sel_e          sel;
  logic [31:0]      pc, next_pc;
  logic [31:0]      sel_target, redirect_pc, boot_pc;
  logic             redirect, misaligned, trap_hit, retire;
  logic [CNT_W-1:0] instret_q;

  pc_seq_target_sel u_target_sel (
    .jmp_valid  (jmp_valid),
    .jmp_target (jmp_target),
    .br_taken   (br_taken),
    .br_target  (br_target),
    .target     (sel_target),
    .redirect   (redirect),
    .misaligned (misaligned)
  );

`ifdef PC_SEQ_MISALIGN_TRAP_EN
  assign trap_hit    = misaligned;
  assign redirect_pc = sel_target;
`else
  logic unused_misaligned;
  assign unused_misaligned = misaligned;
  assign trap_hit    = 1'b0;
  assign redirect_pc = {sel_target[31:2], 2'b00};
`endif

  assign boot_pc  = (BOOT_FROM_PORT != 0) ? boot_addr : RESET_VECTOR;
  assign pc_plus4 = pc + ILEN;
  assign pc_addr  = pc;
  assign pc_valid = (state == S_RUN);
  assign instret  = instret_q;

  always_comb begin
    sel        = next_pc_sel(state, halt_req, stall, resume, redirect, trap_hit);
    next_pc    = pc;
    next_state = state;
    retire     = 1'b0;
    case (sel)
      SEL_BOOT:   next_pc = boot_pc;
      SEL_SEQ:    begin next_pc = pc_plus4;    retire = 1'b1; end
      SEL_TARGET: begin next_pc = redirect_pc; retire = 1'b1; end
      SEL_TRAP:   next_pc = TRAP_VECTOR;
      default:    next_pc = pc;
    endcase
    case (state)
      S_BOOT:  next_state = S_RUN;
      S_RUN:   if (halt_req) next_state = S_HALT;
      S_HALT:  if (resume)   next_state = S_RUN;
      default: next_state = S_BOOT;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= S_BOOT;
      pc        <= RESET_VECTOR;
      instret_q <= '0;
    end else begin
      state <= next_state;
      pc    <= next_pc;
      if (retire) instret_q <= instret_q + CNT_W'(1);
    end
  end

`ifdef PC_SEQ_MISALIGN_TRAP_EN
  logic [3:0]  trap_cause;
  logic [31:0] epc_q;
  logic        trap_valid_q;
  logic        unused_cause;

  // Cause is fixed today; kept so a future mcause output has a home.
  assign trap_cause   = CAUSE_MISALIGN;
  assign unused_cause = ^trap_cause;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      trap_valid_q <= 1'b0;
      epc_q        <= '0;
    end else begin
      trap_valid_q <= (sel == SEL_TRAP);
      if (sel == SEL_TRAP) epc_q <= pc;
    end
  end

  assign trap_valid = trap_valid_q;
  assign epc        = epc_q;
`else
  assign trap_valid = 1'b0;
  assign epc        = '0;
`endif

endmodule

// File: tb/tb_pc_sequencer.sv
// Directed self-checking bench for pc_sequencer; follows PC_SEQ_MISALIGN_TRAP_EN
// for the misaligned-target expectations.
module tb_pc_sequencer;

  localparam logic [31:0] RV = 32'h0000_0000;
  localparam logic [31:0] TV = 32'h0000_0F00;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [31:0] boot_addr;
  logic        stall, br_taken, jmp_valid, halt_req, resume;
  logic [31:0] br_target, jmp_target;
  logic [31:0] pc_addr, pc_plus4, epc;
  logic        pc_valid, trap_valid;
  logic [7:0]  instret;

  int checks = 0;
  int passed = 0;
  logic [7:0] exp_instret;

  pc_sequencer #(
    .RESET_VECTOR   (RV),
    .TRAP_VECTOR    (TV),
    .BOOT_FROM_PORT (1),
    .CNT_W          (8)
  ) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .boot_addr  (boot_addr),
    .stall      (stall),
    .br_taken   (br_taken),
    .br_target  (br_target),
    .jmp_valid  (jmp_valid),
    .jmp_target (jmp_target),
    .halt_req   (halt_req),
    .resume     (resume),
    .pc_addr    (pc_addr),
    .pc_plus4   (pc_plus4),
    .pc_valid   (pc_valid),
    .instret    (instret),
    .trap_valid (trap_valid),
    .epc        (epc)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_inputs();
    stall = 0; br_taken = 0; jmp_valid = 0; halt_req = 0; resume = 0;
    br_target = '0; jmp_target = '0;
  endtask

  task automatic do_jump(input logic [31:0] t);
    jmp_valid = 1; jmp_target = t;
    tick();
    clear_inputs();
    exp_instret = exp_instret + 8'd1;
  endtask

  task automatic test_reset();
    clear_inputs();
    boot_addr = 32'h0000_0200;
    rst_n = 0;
    tick(); tick();
    checks++; if (pc_addr !== RV) $display("FAIL reset_pc got %h exp %h", pc_addr, RV); else passed++;
    checks++; if (pc_valid !== 1'b0) $display("FAIL reset_valid got %b exp 0", pc_valid); else passed++;
    checks++; if (instret !== 8'd0) $display("FAIL reset_instret got %0d exp 0", instret); else passed++;
    checks++; if (trap_valid !== 1'b0) $display("FAIL reset_trap got %b exp 0", trap_valid); else passed++;
    checks++; if (epc !== 32'h0) $display("FAIL reset_epc got %h exp 0", epc); else passed++;
    exp_instret = 0;
  endtask

  task automatic test_boot();
    rst_n = 1;
    #2;
    checks++; if (pc_valid !== 1'b0) $display("FAIL boot_valid got %b exp 0", pc_valid); else passed++;
    tick();
    checks++; if (pc_addr !== 32'h200) $display("FAIL boot_pc got %h exp 00000200", pc_addr); else passed++;
    checks++; if (pc_valid !== 1'b1) $display("FAIL boot_run_valid got %b exp 1", pc_valid); else passed++;
    checks++; if (pc_plus4 !== 32'h204) $display("FAIL boot_plus4 got %h exp 00000204", pc_plus4); else passed++;
    checks++; if (instret !== 8'd0) $display("FAIL boot_instret got %0d exp 0", instret); else passed++;
    tick();
    exp_instret = exp_instret + 8'd1;
    checks++; if (pc_addr !== 32'h204) $display("FAIL seq_pc got %h exp 00000204", pc_addr); else passed++;
    checks++; if (instret !== exp_instret) $display("FAIL seq_instret got %0d exp %0d", instret, exp_instret); else passed++;
  endtask

  task automatic test_branch_jump();
    do_jump(32'h300);
    checks++; if (pc_addr !== 32'h300) $display("FAIL jump_pc got %h exp 00000300", pc_addr); else passed++;
    br_taken = 1; br_target = 32'h400;
    tick(); clear_inputs();
    exp_instret = exp_instret + 8'd1;
    checks++; if (pc_addr !== 32'h400) $display("FAIL branch_pc got %h exp 00000400", pc_addr); else passed++;
    checks++; if (instret !== exp_instret) $display("FAIL branch_instret got %0d exp %0d", instret, exp_instret); else passed++;
    br_taken = 1; br_target = 32'h600; jmp_valid = 1; jmp_target = 32'h501;
    tick(); clear_inputs();
    exp_instret = exp_instret + 8'd1;
    checks++; if (pc_addr !== 32'h500) $display("FAIL jump_wins_pc got %h exp 00000500", pc_addr); else passed++;
  endtask

  task automatic test_stall();
    do_jump(32'h120);
    stall = 1; br_taken = 1; br_target = 32'h1A0; jmp_valid = 1; jmp_target = 32'h900;
    tick(); tick();
    checks++; if (pc_addr !== 32'h120) $display("FAIL stall_pc got %h exp 00000120", pc_addr); else passed++;
    checks++; if (instret !== exp_instret) $display("FAIL stall_instret got %0d exp %0d", instret, exp_instret); else passed++;
    stall = 0; jmp_valid = 0;
    tick(); clear_inputs();
    exp_instret = exp_instret + 8'd1;
    checks++; if (pc_addr !== 32'h1A0) $display("FAIL unstall_pc got %h exp 000001a0", pc_addr); else passed++;
    checks++; if (instret !== exp_instret) $display("FAIL unstall_instret got %0d exp %0d", instret, exp_instret); else passed++;
  endtask

  task automatic test_halt();
    do_jump(32'h80);
    halt_req = 1; br_taken = 1; br_target = 32'h700;
    tick(); clear_inputs();
    checks++; if (pc_valid !== 1'b0) $display("FAIL halt_valid got %b exp 0", pc_valid); else passed++;
    for (int i = 0; i < 5; i++) begin
      jmp_valid = 1; jmp_target = 32'h440; stall = i[0]; halt_req = i[1];
      tick();
      checks++; if (pc_addr !== 32'h80) $display("FAIL halt_hold_pc[%0d] got %h exp 00000080", i, pc_addr); else passed++;
    end
    clear_inputs();
    checks++; if (instret !== exp_instret) $display("FAIL halt_instret got %0d exp %0d", instret, exp_instret); else passed++;
    resume = 1;
    tick(); clear_inputs();
    exp_instret = exp_instret + 8'd1;
    checks++; if (pc_addr !== 32'h84) $display("FAIL resume_pc got %h exp 00000084", pc_addr); else passed++;
    checks++; if (pc_valid !== 1'b1) $display("FAIL resume_valid got %b exp 1", pc_valid); else passed++;
    checks++; if (instret !== exp_instret) $display("FAIL resume_instret got %0d exp %0d", instret, exp_instret); else passed++;
  endtask

  task automatic test_wrap();
    do_jump(32'hFFFF_FFFC);
    checks++; if (pc_plus4 !== 32'h0) $display("FAIL wrap_plus4 got %h exp 00000000", pc_plus4); else passed++;
    tick();
    exp_instret = exp_instret + 8'd1;
    checks++; if (pc_addr !== 32'h0) $display("FAIL wrap_pc got %h exp 00000000", pc_addr); else passed++;
    for (int i = 0; i < 300 && exp_instret != 8'hFF; i++) begin
      tick();
      exp_instret = exp_instret + 8'd1;
    end
    checks++; if (instret !== 8'hFF) $display("FAIL instret_max got %0d exp 255", instret); else passed++;
    tick();
    exp_instret = 8'd0;
    checks++; if (instret !== 8'h00) $display("FAIL instret_wrap got %0d exp 0", instret); else passed++;
  endtask

  task automatic test_misalign();
    do_jump(32'h40);
    jmp_valid = 1; jmp_target = 32'h0000_0102;
    tick(); clear_inputs();
`ifdef PC_SEQ_MISALIGN_TRAP_EN
    checks++; if (pc_addr !== TV) $display("FAIL trap_pc got %h exp %h", pc_addr, TV); else passed++;
    checks++; if (epc !== 32'h40) $display("FAIL trap_epc got %h exp 00000040", epc); else passed++;
    checks++; if (trap_valid !== 1'b1) $display("FAIL trap_pulse got %b exp 1", trap_valid); else passed++;
    checks++; if (instret !== exp_instret) $display("FAIL trap_instret got %0d exp %0d", instret, exp_instret); else passed++;
    tick();
    exp_instret = exp_instret + 8'd1;
    checks++; if (trap_valid !== 1'b0) $display("FAIL trap_pulse_end got %b exp 0", trap_valid); else passed++;
    checks++; if (pc_addr !== TV + 32'd4) $display("FAIL trap_next_pc got %h exp %h", pc_addr, TV + 32'd4); else passed++;
`else
    exp_instret = exp_instret + 8'd1;
    checks++; if (pc_addr !== 32'h100) $display("FAIL misalign_jmp_pc got %h exp 00000100", pc_addr); else passed++;
    checks++; if (trap_valid !== 1'b0) $display("FAIL misalign_trap got %b exp 0", trap_valid); else passed++;
    checks++; if (epc !== 32'h0) $display("FAIL misalign_epc got %h exp 0", epc); else passed++;
    checks++; if (instret !== exp_instret) $display("FAIL misalign_instret got %0d exp %0d", instret, exp_instret); else passed++;
    br_taken = 1; br_target = 32'h0000_0206;
    tick(); clear_inputs();
    exp_instret = exp_instret + 8'd1;
    checks++; if (pc_addr !== 32'h204) $display("FAIL misalign_br_pc got %h exp 00000204", pc_addr); else passed++;
`endif
  endtask

  task automatic test_reset_mid_halt();
    do_jump(32'h3C0);
    halt_req = 1;
    tick(); clear_inputs();
    checks++; if (pc_valid !== 1'b0) $display("FAIL mid_halt_valid got %b exp 0", pc_valid); else passed++;
    #2 rst_n = 0;
    #1;
    checks++; if (pc_addr !== RV) $display("FAIL async_reset_pc got %h exp %h", pc_addr, RV); else passed++;
    checks++; if (instret !== 8'd0) $display("FAIL async_reset_instret got %0d exp 0", instret); else passed++;
    exp_instret = 0;
    tick();
    boot_addr = 32'h0000_0A00;
    rst_n = 1;
    tick();
    checks++; if (pc_addr !== 32'hA00) $display("FAIL reboot_pc got %h exp 00000a00", pc_addr); else passed++;
    checks++; if (pc_valid !== 1'b1) $display("FAIL reboot_valid got %b exp 1", pc_valid); else passed++;
  endtask

  initial begin
    test_reset();
    test_boot();
    test_branch_jump();
    test_stall();
    test_halt();
    test_wrap();
    test_misalign();
    test_reset_mid_halt();
    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule
